// File: rtl/pkt_ctrl_pkg.sv
// rtl/pkt_ctrl_pkg.sv - state encoding, opcode values and sizing helper for pkt_ctrl
package pkt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_OPC,
        ST_STOP,
        ST_EXEC,
        ST_SKIP
    } state_t;

    // NO_OP is all ones at whatever OP_W the instance uses, so it lives in the top.
    typedef enum int {
        OP_OUT_DATA1 = 0,
        OP_OUT_DATA2 = 1,
        OP_OUT_RES   = 2,
        OP_LOAD      = 3,
        OP_LOAD_RES  = 4,
        OP_MUL       = 5,
        OP_MUL_ADD   = 6
    } op_code_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pkt_rx_sampler.sv
// rtl/pkt_rx_sampler.sv - rx synchroniser, start-bit validation and mid-bit strobe timer
module pkt_rx_sampler #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic nRst,
    input  logic rx,
    input  logic arm,
    input  logic run,
    input  logic in_start,
    output logic rxs,
    output logic bit_stb,
    output logic start_ok,
    output logic start_bad
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        tmr_d   = tmr_q;
        // Half a bit from the falling edge lands the first strobe mid start bit.
        if (arm) begin
            tmr_d = TMR_W'(CLKS_PER_BIT / 2 - 1);
        end else if (run) begin
            tmr_d = (tmr_q == '0) ? TMR_W'(CLKS_PER_BIT - 1) : tmr_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            tmr_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            tmr_q   <= tmr_d;
        end
    end

    assign rxs       = sync2_q;
    assign bit_stb   = run && (tmr_q == '0);
    assign start_ok  = in_start && bit_stb && !rxs;
    assign start_bad = in_start && bit_stb && rxs;

endmodule

// File: rtl/pkt_ctrl.sv
// rtl/pkt_ctrl.sv - serial address/opcode frame decoder with timed EXECUTE window
// PKT_CTRL_BCAST_EN: when defined, an all-ones address field matches every instance.
module pkt_ctrl
    import pkt_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int OP_W         = 3,
    parameter int CLKS_PER_BIT = 4,
    parameter int EXEC_LEN     = 32,
    parameter int RES_LEN      = 128,
    parameter int SKIP_BITS    = 12
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [ADDR_W-1:0] address,
    input  logic              rx,
    output logic [OP_W-1:0]   opcode,
    output logic              busy,
    output logic              op_stb,
    output logic              frame_err
);

    localparam int SKIP_LEN = SKIP_BITS * CLKS_PER_BIT;
    localparam int CNT_MAX  = max3(EXEC_LEN - 1, RES_LEN - 1, SKIP_LEN - 1);
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int BIT_MAX  = ((ADDR_W > OP_W) ? ADDR_W : OP_W) - 1;
    localparam int BIT_W    = $clog2(BIT_MAX + 1);
    localparam logic [OP_W-1:0] NO_OP = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [OP_W-1:0]   op_sh_q, op_sh_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic              op_stb_q, op_stb_d;
    logic              frame_err_q, frame_err_d;

    logic              arm, run, in_start;
    logic              rxs, bit_stb, start_ok, start_bad;
    logic [ADDR_W-1:0] addr_next;
    logic [OP_W-1:0]   op_next;
    logic              addr_match;

    pkt_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
        .clk       (clk),
        .nRst      (nRst),
        .rx        (rx),
        .arm       (arm),
        .run       (run),
        .in_start  (in_start),
        .rxs       (rxs),
        .bit_stb   (bit_stb),
        .start_ok  (start_ok),
        .start_bad (start_bad)
    );

    assign addr_next = {rxs, addr_sh_q[ADDR_W-1:1]};
    assign op_next   = {rxs, op_sh_q[OP_W-1:1]};

    // Compared against the live address only at the last address bit.
`ifdef PKT_CTRL_BCAST_EN
    assign addr_match = (addr_next == address) || (&addr_next);
`else
    assign addr_match = (addr_next == address);
`endif

    always_comb begin
        state_d     = state_q;
        addr_sh_d   = addr_sh_q;
        op_sh_d     = op_sh_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        opcode_d    = opcode_q;
        op_stb_d    = 1'b0;
        frame_err_d = 1'b0;
        arm         = 1'b0;
        run         = 1'b0;
        in_start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                opcode_d = NO_OP;
                if (!rxs) begin
                    arm     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                run      = 1'b1;
                in_start = 1'b1;
                if (start_ok) begin
                    bit_cnt_d = '0;
                    state_d   = ST_ADDR;
                end else if (start_bad) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                run = 1'b1;
                if (bit_stb) begin
                    addr_sh_d = addr_next;
                    if (bit_cnt_q == BIT_W'(ADDR_W - 1)) begin
                        bit_cnt_d = '0;
                        if (addr_match) begin
                            state_d = ST_OPC;
                        end else begin
                            cnt_d   = CNT_W'(SKIP_LEN - 1);
                            state_d = ST_SKIP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_OPC: begin
                run = 1'b1;
                if (bit_stb) begin
                    op_sh_d = op_next;
                    if (bit_cnt_q == BIT_W'(OP_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                run = 1'b1;
                if (bit_stb) begin
                    if (rxs) begin
                        opcode_d = op_sh_q;
                        op_stb_d = 1'b1;
                        cnt_d    = (op_sh_q == OP_W'(OP_OUT_RES)) ? CNT_W'(RES_LEN - 1)
                                                                  : CNT_W'(EXEC_LEN - 1);
                        state_d  = ST_EXEC;
                    end else begin
                        frame_err_d = 1'b1;
                        opcode_d    = NO_OP;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    opcode_d = NO_OP;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Multiply opcodes are a single-cycle trigger inside the window.
                    if (opcode_q == OP_W'(OP_MUL) || opcode_q == OP_W'(OP_MUL_ADD)) begin
                        opcode_d = NO_OP;
                    end
                end
            end
            ST_SKIP: begin
                if (cnt_q == '0) begin
                    addr_sh_d = '0;
                    op_sh_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            addr_sh_q   <= '0;
            op_sh_q     <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            opcode_q    <= NO_OP;
            op_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_sh_q   <= addr_sh_d;
            op_sh_q     <= op_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            op_stb_q    <= op_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign opcode    = opcode_q;
    assign busy      = (state_q != ST_IDLE);
    assign op_stb    = op_stb_q;
    assign frame_err = frame_err_q;

endmodule
